serial_wb_if_bridge: RTL and testbench

- UART-receive to Wishbone-master bridge: turns 8N1 command frames on one serial RX line into single Wishbone classic bus cycles.
- Drives a 7-bit-address, 8-bit-data register slave such as the CSR block.
- Command byte {we, adr[6:0]}:
  - Write (we=1) is followed by one data byte.
  - Read (we=0) has no payload.

---
 rtl/serial_wb_if_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_serial_wb_if_bridge.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_wb_if_bridge.sv
// UART-RX (8N1) to Wishbone classic master: {we, adr[6:0]} [+ data byte] -> one bus cycle.
// Optional SERIAL_WB_TX_EN adds serial_tx returning read data / 0x00 write ack / 0xFF timeout.
module serial_wb_if_bridge #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_rx,
  output logic [6:0] wb_adr_o,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  input  logic       wb_ack_i,
  output logic       wb_cyc_o
`ifdef SERIAL_WB_TX_EN
  ,
  output logic       serial_tx
`endif
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CW      = $clog2(BIT_CYC + 1);
  localparam int TW      = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_CMD, P_DATA, P_BUS} p_state_t;

  logic [1:0]    sync;
  logic          rx_s;
  rx_state_t     rs;
  logic          armed;
  logic [CW-1:0] rcnt;
  logic [2:0]    bitn;
  logic [7:0]    sh, rx_byte;
  logic          byte_valid, frame_err;

  p_state_t      ps;
  logic [6:0]    adr_l;
  logic          we_l, act;
  logic [TW-1:0] tmo;
  logic          hold_vld;
  logic [7:0]    hold_byte, rd_data;
  logic          in_vld, bus_go;
  logic [7:0]    in_byte;

  // rd_data is an observation register only; keep it from looking dangling.
  logic unused_rd;
  assign unused_rd = ^rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], serial_rx};
  end
  assign rx_s = sync[1];

  // armed only sets on a high level in IDLE, so a held-low break cannot retrigger
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs <= R_IDLE; armed <= 1'b0; rcnt <= '0; bitn <= '0;
      sh <= '0; rx_byte <= '0; byte_valid <= 1'b0; frame_err <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rs)
        R_IDLE: begin
          rcnt <= '0;
          if (rx_s) armed <= 1'b1;
          else if (armed) begin
            armed <= 1'b0;
            rs    <= R_START;
          end
        end
        R_START: begin
          if (rcnt == CW'(HALF - 1)) begin
            rcnt <= '0;
            bitn <= '0;
            rs   <= rx_s ? R_IDLE : R_DATA;
          end else rcnt <= rcnt + 1'b1;
        end
        R_DATA: begin
          if (rcnt == CW'(BIT_CYC - 1)) begin
            rcnt <= '0;
            sh   <= {rx_s, sh[7:1]};
            bitn <= bitn + 1'b1;
            if (bitn == 3'd7) rs <= R_STOP;
          end else rcnt <= rcnt + 1'b1;
        end
        R_STOP: begin
          if (rcnt == CW'(BIT_CYC - 1)) begin
            rcnt <= '0;
            rs   <= R_IDLE;
            if (rx_s) begin
              byte_valid <= 1'b1;
              rx_byte    <= sh;
            end else frame_err <= 1'b1;
          end else rcnt <= rcnt + 1'b1;
        end
        default: rs <= R_IDLE;
      endcase
    end
  end

  // a fresh byte always wins over the holding register
  assign in_vld  = byte_valid | hold_vld;
  assign in_byte = byte_valid ? rx_byte : hold_byte;

`ifdef SERIAL_WB_TX_EN
  logic          resp_evt, resp_vld, tx_busy;
  logic [7:0]    resp_val, resp_byte;
  logic [9:0]    tx_sh;
  logic [3:0]    tx_bits;
  logic [CW-1:0] tx_cnt;
  assign bus_go = ~resp_vld;
`else
  assign bus_go = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps <= P_CMD; adr_l <= '0; we_l <= 1'b0; act <= 1'b0; tmo <= '0;
      hold_vld <= 1'b0; hold_byte <= '0; rd_data <= '0;
      wb_adr_o <= '0; wb_dat_o <= '0; wb_we_o <= 1'b0; wb_stb_o <= 1'b0; wb_cyc_o <= 1'b0;
`ifdef SERIAL_WB_TX_EN
      resp_evt <= 1'b0; resp_val <= '0;
`endif
    end else begin
`ifdef SERIAL_WB_TX_EN
      resp_evt <= 1'b0;
`endif
      case (ps)
        P_CMD: begin
          if (frame_err) hold_vld <= 1'b0;
          else if (in_vld) begin
            hold_vld <= 1'b0;
            adr_l    <= in_byte[6:0];
            we_l     <= in_byte[7];
            ps       <= in_byte[7] ? P_DATA : P_BUS;
          end
        end
        P_DATA: begin
          if (frame_err) begin
            hold_vld <= 1'b0;
            ps       <= P_CMD;
          end else if (in_vld) begin
            hold_vld <= 1'b0;
            wb_dat_o <= in_byte;
            ps       <= P_BUS;
          end
        end
        P_BUS: begin
          if (byte_valid) begin
            hold_vld  <= 1'b1;
            hold_byte <= rx_byte;
          end else if (frame_err) hold_vld <= 1'b0;
          if (!act) begin
            if (bus_go) begin
              act <= 1'b1; tmo <= '0;
              wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1;
              wb_we_o  <= we_l; wb_adr_o <= adr_l;
            end
          end else if (wb_ack_i || tmo == TW'(ACK_TIMEOUT - 1)) begin
            act <= 1'b0;
            ps  <= P_CMD;
            wb_cyc_o <= 1'b0; wb_stb_o <= 1'b0; wb_we_o <= 1'b0;
            if (wb_ack_i && !we_l) rd_data <= wb_dat_i;
`ifdef SERIAL_WB_TX_EN
            resp_evt <= 1'b1;
            resp_val <= !wb_ack_i ? 8'hFF : (we_l ? 8'h00 : wb_dat_i);
`endif
          end else tmo <= tmo + 1'b1;
        end
        default: ps <= P_CMD;
      endcase
    end
  end

`ifdef SERIAL_WB_TX_EN
  // one pending response slot; the bus side stalls while it is occupied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_vld <= 1'b0; resp_byte <= '0; tx_busy <= 1'b0;
      tx_sh <= '1; tx_bits <= '0; tx_cnt <= '0; serial_tx <= 1'b1;
    end else begin
      if (!tx_busy) begin
        if (resp_vld) begin
          tx_busy  <= 1'b1;
          tx_sh    <= {1'b1, resp_byte, 1'b0};
          tx_bits  <= '0;
          tx_cnt   <= '0;
          resp_vld <= 1'b0;
        end
      end else if (tx_cnt == CW'(BIT_CYC - 1)) begin
        tx_cnt  <= '0;
        tx_sh   <= {1'b1, tx_sh[9:1]};
        tx_bits <= tx_bits + 1'b1;
        if (tx_bits == 4'd9) tx_busy <= 1'b0;
      end else tx_cnt <= tx_cnt + 1'b1;
      if (resp_evt) begin
        resp_vld  <= 1'b1;
        resp_byte <= resp_val;
      end
      serial_tx <= tx_busy ? tx_sh[0] : 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_wb_if_bridge.sv
// Scoreboarded bench: serial command frames in, Wishbone cycles checked against a register-file model.
module tb_serial_wb_if_bridge;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int TMO      = 255;

  logic       clk = 1'b0, rst = 1'b0, serial_rx = 1'b1;
  logic [6:0] wb_adr_o;
  logic [7:0] wb_dat_i = '0, wb_dat_o;
  logic       wb_we_o, wb_stb_o, wb_ack_i = 1'b0, wb_cyc_o;
`ifdef SERIAL_WB_TX_EN
  logic       serial_tx;
`endif

  always #5 clk = ~clk;

  serial_wb_if_bridge #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .serial_rx(serial_rx),
    .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o)
`ifdef SERIAL_WB_TX_EN
    , .serial_tx(serial_tx)
`endif
  );

  // kind: 0 = acked, 1 = timeout, 2 = aborted by reset
  typedef struct { bit we; bit [6:0] adr; bit [7:0] dat; int kind; } exp_t;
  exp_t     expq[$];
  bit [7:0] txq[$];
  bit [7:0] ref_mem[128];
  bit [7:0] slv_mem[128];
  int       tests = 0, fails = 0, inv_err = 0, ncyc = 0;
  int       ack_dly = 0;
  bit       no_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // register slave: acks after ack_dly wait states, commits writes on ack
  initial begin
    int w = 0;
    forever begin
      @(negedge clk);
      if (wb_ack_i) begin
        wb_ack_i = 1'b0; w = 0;
      end else if (wb_cyc_o && wb_stb_o && !no_ack) begin
        if (w >= ack_dly) begin
          wb_ack_i = 1'b1;
          wb_dat_i = slv_mem[wb_adr_o];
          if (wb_we_o) slv_mem[wb_adr_o] = wb_dat_o;
        end else w++;
      end else if (!wb_cyc_o) w = 0;
    end
  end

  // bus monitor / scoreboard
  initial begin
    bit in_cyc = 1'b0;
    int len = 0;
    exp_t e;
    logic [6:0] a0; logic w0; logic [7:0] d0;
    e.kind = 2;
    forever begin
      @(negedge clk);
      if (wb_cyc_o !== wb_stb_o || (!wb_cyc_o && wb_we_o !== 1'b0)) inv_err++;
      if (wb_cyc_o && !in_cyc) begin
        in_cyc = 1'b1; len = 1; ncyc++;
        a0 = wb_adr_o; w0 = wb_we_o; d0 = wb_dat_o;
        check("cycle_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check("cyc_we", wb_we_o, e.we);
          check("cyc_adr", wb_adr_o, e.adr);
          if (e.we) check("cyc_wdat", wb_dat_o, e.dat);
        end else e.kind = 2;
      end else if (wb_cyc_o) begin
        len++;
        if (wb_adr_o !== a0 || wb_we_o !== w0 || wb_dat_o !== d0) inv_err++;
      end else if (in_cyc) begin
        in_cyc = 1'b0;
        if (e.kind == 1) begin
          check("timeout_len", len, TMO);
          txq.push_back(8'hFF);
        end else if (e.kind == 0) begin
          if (!e.we) check("rd_data", dut.rd_data, e.dat);
          txq.push_back(e.we ? 8'h00 : e.dat);
        end
      end
    end
  end

`ifdef SERIAL_WB_TX_EN
  initial begin
    forever begin
      @(negedge clk);
      if (serial_tx === 1'b0) begin
        bit [7:0] b;
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = serial_tx;
        end
        repeat (BIT) @(negedge clk);
        check("tx_stop", serial_tx, 1);
        check("tx_expected", txq.size() > 0, 1);
        if (txq.size() > 0) check("tx_byte", b, txq.pop_front());
      end
    end
  end
`endif

  task automatic send_byte(input bit [7:0] b, input bit stop = 1'b1);
    @(negedge clk);
    serial_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    serial_rx = stop;
    repeat (BIT) @(negedge clk);
    serial_rx = 1'b1;
  endtask

  task automatic do_write(input bit [6:0] a, input bit [7:0] d, input int kind = 0, input int gap = 0);
    exp_t e;
    e.we = 1'b1; e.adr = a; e.dat = d; e.kind = kind;
    if (kind == 0) ref_mem[a] = d;
    expq.push_back(e);
    send_byte({1'b1, a});
    repeat (gap) @(negedge clk);
    send_byte(d);
  endtask

  task automatic do_read(input bit [6:0] a);
    exp_t e;
    e.we = 1'b0; e.adr = a; e.dat = ref_mem[a]; e.kind = 0;
    expq.push_back(e);
    send_byte({1'b0, a});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((expq.size() != 0 || wb_cyc_o) && n < 5000) begin
      @(negedge clk); n++;
    end
    repeat (20) @(negedge clk);
    check(name, expq.size(), 0);
  endtask

  task automatic check_outs_zero(input string name);
    check(name, {wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o}, 0);
  endtask

  initial begin
    #900us;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'($urandom);
      slv_mem[i] = ref_mem[i];
    end
    #10 rst = 1'b1;
    #1 check_outs_zero("reset_outputs");
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    check("idle_no_cycle", ncyc, 0);

    do_write(7'h02, 8'hAB);
    wait_idle("write_done");
    check("slave_reg2", slv_mem[2], 8'hAB);
    check("wdat_held", wb_dat_o, 8'hAB);
    do_read(7'h02);
    wait_idle("readback_done");

    slv_mem[5] = 8'h3C; ref_mem[5] = 8'h3C;
    do_read(7'h05);
    wait_idle("read_done");

    n0 = ncyc;
    @(negedge clk) serial_rx = 1'b0;
    repeat (3) @(negedge clk);
    serial_rx = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_no_cycle", ncyc, n0);

    send_byte(8'h82, 1'b0);
    repeat (20) @(negedge clk);
    do_read(7'h05);
    wait_idle("framing_then_read");

    n0 = ncyc;
    serial_rx = 1'b0;
    repeat (300) @(negedge clk);
    serial_rx = 1'b1;
    repeat (50) @(negedge clk);
    check("break_no_cycle", ncyc, n0);
    do_read(7'h02);
    wait_idle("after_break");

    no_ack = 1'b1;
    do_write(7'h07, 8'h55, 1);
    wait_idle("timeout_done");
    no_ack = 1'b0;
    do_read(7'h07);
    wait_idle("after_timeout");

    // second command lands while the first read is still waiting for ack
    ack_dly = 150;
    do_read(7'h01);
    do_read(7'h03);
    wait_idle("held_byte");
    ack_dly = 0;

    for (int k = 0; k < 20; k++) begin
      ack_dly = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) do_write(7'($urandom), 8'($urandom), 0, $urandom_range(0, 30));
      else do_read(7'($urandom));
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_idle("random_done");
    ack_dly = 0;

    begin
      exp_t e;
      no_ack = 1'b1;
      e.we = 1'b1; e.adr = 7'h09; e.dat = 8'h66; e.kind = 2;
      expq.push_back(e);
      send_byte(8'h89);
      send_byte(8'h66);
      for (int i = 0; i < 3000 && !wb_cyc_o; i++) @(negedge clk);
      check("abort_cycle_started", wb_cyc_o, 1);
      #2 rst = 1'b1;
      #1 check_outs_zero("midcycle_reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      no_ack = 1'b0;
    end
    do_read(7'h09);
    wait_idle("after_reset");

`ifdef SERIAL_WB_TX_EN
    for (int i = 0; i < 3000 && txq.size() != 0; i++) @(negedge clk);
    check("tx_drained", txq.size(), 0);
`endif
    check("bus_invariants", inv_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
